decode_ctrl_pipe: RTL and testbench
===================================

// Module: decode_ctrl_pipe
// PURPOSE
// - Registered, handshaked decode stage for the RV32I(+M) core; successor to the combinational control decode.
// - Decodes one 32-bit instruction per accepted beat into the datapath control bundle and holds it in an output register.
// - Adds valid/ready flow control, flush, illegal-instruction detection and a multi-cycle hold for M-extension ops.
// - Sits between instruction fetch and the execute stage.
// PARAMETERS
// - INSTR_W     32  instruction width; only 32 is supported.
// - ALU_SRC_W   5   alu_src width, {funct7[5], funct7[0], funct3}.
// - MULDIV_LAT  4   cycles an M-op holds the stage before out_valid rises; legal range 1..15.
// PORTS
// - clk           in   1          rising-edge clock.
// - rst_n         in   1          asynchronous, active-low reset.
// - flush         in   1          kill the in-flight decode and return to S_RUN.
// - in_valid      in   1          instr is valid.
// - in_ready      out  1          stage can accept instr this cycle.
// - instr         in   INSTR_W    raw instruction word.
// - out_valid     out  1          control bundle is valid.
// - out_ready     in   1          execute consumes the bundle.
// - alu_src       out  ALU_SRC_W  ALU operation select.
// - imm_src       out  3          0=I, 1=S, 2=B, 3=U, 4=J.
// - branch_src    out  3          branch condition (funct3); 3'b010 for JAL/JALR.
// - mem_write     out  1          store.
// - alu_mux_src   out  2          {A=PC, B=imm}.
// - wb_src        out  2          0=ALU, 1=MEM, 2=PC+4, 3=IMM.
// - reg_write     out  1          register-file write enable.
// - branch_valid  out  1          B-type, JAL or JALR.
// - illegal_instr out  1          unrecognised opcode/funct; all side-effect enables are forced to 0.
// - busy          out  1          state == S_MD_HOLD.
// BEHAVIOUR
// - Reset (async, rst_n=0): every output register is 0; state=S_RUN; hold counter=0.
//   - in_ready=1 after reset; it is combinational from state/out_valid/out_ready.
// - Handshake and accept:
//   - in_ready = (state==S_RUN) && (!out_valid || out_ready).
//   - Accept = in_valid && in_ready && !flush; the decoded bundle is registered on that edge.
//   - Latency is 1 cycle.
//   - A bundle is held stable while out_valid && !out_ready.
//   - With no new accept, out_ready=1 clears out_valid.
// - Decode table:
//   - R-type: alu_src = {f7[5], f7[0], f3}.
//   - I-ALU: alu_src = {f3==3'b101 ? f7[5] : 0, 0, f3}.
//   - LOAD, STORE, JAL, JALR, LUI, AUIPC: alu_src = 0 (ADD). BRANCH: alu_src = 5'b10000 (SUB).
//   - alu_mux_src: 2'b01 for I/LOAD/STORE/JALR, 2'b11 for AUIPC, 2'b00 otherwise.
//   - LOAD wb=1. JAL/JALR wb=2. LUI wb=3.
//   - STORE/BRANCH: reg_write=0. All other legal classes: reg_write=1.
// - Illegal instructions:
//   - Triggers: undefined opcode; R-type f7 not in {0, 0x20, 0x01 (M only)}; f7=0x20 with f3 not in {000, 101}.
//   - Response: illegal_instr=1, reg_write=mem_write=branch_valid=0, other fields 0; out_valid still asserts.
// - FSM S_RUN -> S_MD_HOLD:
//   - Transition on accept of an M-op (opcode 0110011, f7=0000001) when MULDIV_LAT>1.
//   - On entry: cnt=MULDIV_LAT-1, out_valid=0, bundle registered.
// - FSM S_MD_HOLD:
//   - Decrements cnt each cycle; in_ready=0.
//   - When cnt reaches 1, the next edge sets out_valid=1 and returns to S_RUN.
//   - Total instr-to-out_valid latency is MULDIV_LAT cycles.
//   - MULDIV_LAT=1: M-ops behave like single-cycle ops and never enter S_MD_HOLD.
// - Flush:
//   - Highest priority. Next edge: out_valid=0, state=S_RUN, cnt=0; a same-cycle in_valid is dropped.
//   - Bundle fields are not cleared.
// - Reset asserted mid-hold: immediate return to reset values; no partial bundle is emitted.
// - cnt is 4 bits; it never wraps, because MULDIV_LAT<=15 is enforced by an elaboration-time check.
// CONFIGURATION
// - MULDIV_EN defined:
//   - f7=0000001 R-type ops decode with alu_src={0, 1, f3} and use the S_MD_HOLD path.
// - MULDIV_EN undefined:
//   - Those encodings set illegal_instr=1; S_MD_HOLD is unreachable.
//   - busy is tied to 0; MULDIV_LAT is ignored.
// TESTING
// - T1 Reset: rst_n=0 mid-stream -> all outputs 0 and in_ready=1 within the same cycle (async).
// - T2 Basic decode: accept 0x00C58533 (add a0,a1,a2), out_ready=1.
//   - Next cycle: out_valid=1, alu_src=0, reg_write=1, wb_src=0.
// - T3 Backpressure: accept 0x0000A103 (lw), out_ready=0 for 3 cycles.
//   - Bundle stable, in_ready=0, wb_src=1, imm_src=0.
// - T4 M-op with MULDIV_EN, MULDIV_LAT=4: accept 0x02C58533 (mul).
//   - busy=1 for 3 cycles; out_valid rises exactly 4 cycles after accept; alu_src=5'b01000.
// - T5 Flush during S_MD_HOLD: flush on hold cycle 2 -> next cycle busy=0, out_valid=0, in_ready=1.
// - T6 Illegal: accept 0xFFFFFFFF; separately, without MULDIV_EN accept 0x02C58533.
//   - Both: out_valid=1, illegal_instr=1, reg_write=0, mem_write=0.

Source files
------------

// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe: registered RV32I(+M) decode stage with valid/ready flow control, flush and illegal detection.
// Define MULDIV_EN to decode M-extension ops and hold them for MULDIV_LAT cycles.
module decode_ctrl_pipe #(
  parameter int INSTR_W    = 32,
  parameter int ALU_SRC_W  = 5,
  parameter int MULDIV_LAT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_W-1:0]   instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ALU_SRC_W-1:0] alu_src,
  output logic [2:0]           imm_src,
  output logic [2:0]           branch_src,
  output logic                 mem_write,
  output logic [1:0]           alu_mux_src,
  output logic [1:0]           wb_src,
  output logic                 reg_write,
  output logic                 branch_valid,
  output logic                 illegal_instr,
  output logic                 busy
);
  typedef enum logic {S_RUN, S_MD_HOLD} state_t;
  typedef struct packed {
    logic [ALU_SRC_W-1:0] alu;
    logic [2:0]           imm;
    logic [2:0]           br;
    logic                 mw;
    logic [1:0]           mux;
    logic [1:0]           wb;
    logic                 rw;
    logic                 bv;
    logic                 ill;
  } bundle_t;
  localparam logic [3:0] MD_CNT = 4'(MULDIV_LAT - 1);
  localparam bit MD_MULTI = MULDIV_LAT > 1;
  if (INSTR_W != 32) begin : g_w_chk
    $error("INSTR_W must be 32");
  end
  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_out_valid, w_valid_nxt;
  bundle_t     r_dec, w_dec;
  logic        w_md, w_accept, w_unused;
  logic [6:0]  w_op, w_f7;
  logic [2:0]  w_f3;
`ifdef MULDIV_EN
  localparam bit MD_EN = 1'b1;
  if (MULDIV_LAT < 1 || MULDIV_LAT > 15) begin : g_lat_chk
    $error("MULDIV_LAT must be in 1..15");
  end
  assign busy = r_state == S_MD_HOLD;
`else
  localparam bit MD_EN = 1'b0;
  assign busy = 1'b0;
`endif
  assign w_op     = instr[6:0];
  assign w_f3     = instr[14:12];
  assign w_f7     = instr[31:25];
  assign w_unused = ^{instr[24:15], instr[11:7]};
  assign in_ready = (r_state == S_RUN) && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready && !flush;
  always_comb begin
    w_dec = '0;
    w_md  = 1'b0;
    case (w_op)
      7'b0110011: begin
        w_md = MD_EN && (w_f7 == 7'h01);
        if (w_f7 == 7'h00 || (w_f7 == 7'h20 && (w_f3 == 3'b000 || w_f3 == 3'b101)) || w_md) begin
          w_dec.alu = ALU_SRC_W'({w_f7[5], w_f7[0], w_f3});
          w_dec.rw  = 1'b1;
        end else
          w_dec.ill = 1'b1;
      end
      7'b0010011: begin
        w_dec.alu = ALU_SRC_W'({w_f3 == 3'b101 ? w_f7[5] : 1'b0, 1'b0, w_f3});
        w_dec.mux = 2'b01;
        w_dec.rw  = 1'b1;
      end
      7'b0000011: begin
        w_dec.mux = 2'b01;
        w_dec.wb  = 2'd1;
        w_dec.rw  = 1'b1;
      end
      7'b0100011: begin
        w_dec.imm = 3'd1;
        w_dec.mux = 2'b01;
        w_dec.mw  = 1'b1;
      end
      7'b1100011: begin
        w_dec.alu = ALU_SRC_W'(5'b10000);
        w_dec.imm = 3'd2;
        w_dec.br  = w_f3;
        w_dec.bv  = 1'b1;
      end
      7'b1101111: begin
        w_dec.imm = 3'd4;
        w_dec.br  = 3'b010;
        w_dec.wb  = 2'd2;
        w_dec.rw  = 1'b1;
        w_dec.bv  = 1'b1;
      end
      7'b1100111: begin
        w_dec.br  = 3'b010;
        w_dec.mux = 2'b01;
        w_dec.wb  = 2'd2;
        w_dec.rw  = 1'b1;
        w_dec.bv  = 1'b1;
      end
      7'b0110111: begin
        w_dec.imm = 3'd3;
        w_dec.wb  = 2'd3;
        w_dec.rw  = 1'b1;
      end
      7'b0010111: begin
        w_dec.imm = 3'd3;
        w_dec.mux = 2'b11;
        w_dec.rw  = 1'b1;
      end
      default: w_dec.ill = 1'b1;
    endcase
  end
  // Flush wins over everything; an M-op parks in S_MD_HOLD with out_valid low until the count expires.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_valid_nxt = r_out_valid && !out_ready;
    if (flush) begin
      w_state_nxt = S_RUN;
      w_cnt_nxt   = '0;
      w_valid_nxt = 1'b0;
    end else if (r_state == S_MD_HOLD) begin
      w_cnt_nxt   = r_cnt - 4'd1;
      w_valid_nxt = r_cnt == 4'd1;
      w_state_nxt = r_cnt == 4'd1 ? S_RUN : S_MD_HOLD;
    end else if (w_accept) begin
      w_state_nxt = (w_md && MD_MULTI) ? S_MD_HOLD : S_RUN;
      w_cnt_nxt   = (w_md && MD_MULTI) ? MD_CNT : r_cnt;
      w_valid_nxt = !(w_md && MD_MULTI);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_dec       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out_valid <= w_valid_nxt;
      if (w_accept) r_dec <= w_dec;
    end
  end
  assign out_valid     = r_out_valid;
  assign alu_src       = r_dec.alu;
  assign imm_src       = r_dec.imm;
  assign branch_src    = r_dec.br;
  assign mem_write     = r_dec.mw;
  assign alu_mux_src   = r_dec.mux;
  assign wb_src        = r_dec.wb;
  assign reg_write     = r_dec.rw;
  assign branch_valid  = r_dec.bv;
  assign illegal_instr = r_dec.ill;
endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// tb_decode_ctrl_pipe: table-driven decode vectors plus hand-written handshake, M-op hold, flush and reset sequences.
module tb_decode_ctrl_pipe;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] instr = '0;
  logic        in_ready, out_valid, mem_write, reg_write, branch_valid, illegal_instr, busy;
  logic [4:0]  alu_src;
  logic [2:0]  imm_src, branch_src;
  logic [1:0]  alu_mux_src, wb_src;
  logic [18:0] act;
  int checks = 0, failures = 0;
  decode_ctrl_pipe #(.INSTR_W(32), .ALU_SRC_W(5), .MULDIV_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .out_valid(out_valid), .out_ready(out_ready), .alu_src(alu_src),
    .imm_src(imm_src), .branch_src(branch_src), .mem_write(mem_write), .alu_mux_src(alu_mux_src),
    .wb_src(wb_src), .reg_write(reg_write), .branch_valid(branch_valid),
    .illegal_instr(illegal_instr), .busy(busy)
  );
  always #5 clk = ~clk;
  assign act = {alu_src, imm_src, branch_src, mem_write, alu_mux_src, wb_src, reg_write, branch_valid, illegal_instr};
  typedef struct {
    logic [31:0] instr;
    logic [18:0] exp;
  } vec_t;
  vec_t vecs[$];
  function automatic logic [18:0] mk(logic [4:0] alu, logic [2:0] imm, logic [2:0] br, logic mw,
                                     logic [1:0] mux, logic [1:0] wb, logic rw, logic bv, logic ill);
    return {alu, imm, br, mw, mux, wb, rw, bv, ill};
  endfunction
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, a, e);
    end
  endtask
  localparam logic [18:0] ILL = 19'd1;
  initial begin
    vecs.push_back('{32'h00C58533, mk(5'h00, 3'd0, 3'd0, 1'b0, 2'b00, 2'd0, 1'b1, 1'b0, 1'b0)});
    vecs.push_back('{32'h40C58533, mk(5'h10, 3'd0, 3'd0, 1'b0, 2'b00, 2'd0, 1'b1, 1'b0, 1'b0)});
    vecs.push_back('{32'h40C5D533, mk(5'h15, 3'd0, 3'd0, 1'b0, 2'b00, 2'd0, 1'b1, 1'b0, 1'b0)});
    vecs.push_back('{32'h40C59533, ILL});
    vecs.push_back('{32'h04C58533, ILL});
    vecs.push_back('{32'h00558513, mk(5'h00, 3'd0, 3'd0, 1'b0, 2'b01, 2'd0, 1'b1, 1'b0, 1'b0)});
    vecs.push_back('{32'h4035D513, mk(5'h15, 3'd0, 3'd0, 1'b0, 2'b01, 2'd0, 1'b1, 1'b0, 1'b0)});
    vecs.push_back('{32'h4005F513, mk(5'h07, 3'd0, 3'd0, 1'b0, 2'b01, 2'd0, 1'b1, 1'b0, 1'b0)});
    vecs.push_back('{32'h0000A103, mk(5'h00, 3'd0, 3'd0, 1'b0, 2'b01, 2'd1, 1'b1, 1'b0, 1'b0)});
    vecs.push_back('{32'h00A5A223, mk(5'h00, 3'd1, 3'd0, 1'b1, 2'b01, 2'd0, 1'b0, 1'b0, 1'b0)});
    vecs.push_back('{32'h00B51463, mk(5'h10, 3'd2, 3'd1, 1'b0, 2'b00, 2'd0, 1'b0, 1'b1, 1'b0)});
    vecs.push_back('{32'h010000EF, mk(5'h00, 3'd4, 3'd2, 1'b0, 2'b00, 2'd2, 1'b1, 1'b1, 1'b0)});
    vecs.push_back('{32'h00008067, mk(5'h00, 3'd0, 3'd2, 1'b0, 2'b01, 2'd2, 1'b1, 1'b1, 1'b0)});
    vecs.push_back('{32'h12345537, mk(5'h00, 3'd3, 3'd0, 1'b0, 2'b00, 2'd3, 1'b1, 1'b0, 1'b0)});
    vecs.push_back('{32'h00001517, mk(5'h00, 3'd3, 3'd0, 1'b0, 2'b11, 2'd0, 1'b1, 1'b0, 1'b0)});
    vecs.push_back('{32'hFFFFFFFF, ILL});
    vecs.push_back('{32'h00000000, ILL});
`ifndef MULDIV_EN
    vecs.push_back('{32'h02C58533, ILL});
`endif
    #3 chk("reset_state", 32'({out_valid, act, busy, in_ready}), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i <= vecs.size(); i++) begin
      @(negedge clk);
      if (i > 0) chk($sformatf("vec%0d_%h", i - 1, vecs[i-1].instr), 32'({out_valid, act}), 32'({1'b1, vecs[i-1].exp}));
      if (i < vecs.size()) begin
        in_valid = 1'b1;
        instr = vecs[i].instr;
      end else in_valid = 1'b0;
    end
    @(negedge clk);
    chk("idle_clear", 32'(out_valid), 32'd0);
    in_valid = 1'b1;
    instr = 32'h0000A103;
    @(negedge clk);
    chk("lw_accept", 32'({out_valid, act}), 32'({1'b1, vecs[8].exp}));
    out_ready = 1'b0;
    instr = 32'h00C58533;
    #1 chk("bp_in_ready", 32'(in_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", c), 32'({out_valid, in_ready, act}), 32'({2'b10, vecs[8].exp}));
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    #1 chk("bp_release_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("bp_drain", 32'(out_valid), 32'd0);
    in_valid = 1'b1;
    instr = 32'h40C58533;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_drop", 32'({out_valid, act}), 32'({1'b0, vecs[8].exp}));
    in_valid = 1'b1;
    instr = 32'h00C58533;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    out_ready = 1'b1;
    chk("flush_valid", 32'({out_valid, in_ready}), 32'd1);
`ifdef MULDIV_EN
    in_valid = 1'b1;
    instr = 32'h02C58533;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("md_hold%0d", c), 32'({busy, out_valid, in_ready}), 32'd4);
      @(negedge clk);
    end
    chk("md_done", 32'({busy, out_valid, in_ready}), 32'd3);
    chk("md_bundle", 32'(act), 32'(mk(5'h08, 3'd0, 3'd0, 1'b0, 2'b00, 2'd0, 1'b1, 1'b0, 1'b0)));
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("md_flush", 32'({busy, out_valid, in_ready}), 32'd1);
    repeat (4) @(negedge clk);
    chk("md_flush_quiet", 32'({busy, out_valid}), 32'd0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("md_reset", 32'({busy, out_valid, act, in_ready}), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("md_reset_quiet", 32'({busy, out_valid}), 32'd0);
`endif
    in_valid = 1'b1;
    instr = 32'h00C58533;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_reset_valid", 32'({out_valid, act}), 32'({1'b1, vecs[0].exp}));
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 32'({out_valid, act, busy, in_ready}), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
